// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_unit
//  Purpose  : Iterative RV32M multiply/divide unit sitting beside the EX-stage
//             ALU. One op is accepted per req_valid/req_ready handshake.
//             Multiplies retire MUL_STEP multiplier bits per cycle (shift-add).
//             Divides retire one quotient bit per cycle (restoring).
//             The result is held on resp_data/resp_valid until resp_ready.
//  Ports    : clk, rst (sync, active high), flush (kill in-flight op)
//             req_valid/req_ready, funct3, rs1, rs2     - request side
//             resp_valid/resp_ready, resp_data           - response side
//             busy                                       - op in flight
//  Revision : 1.0  initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    // Terminal counts: the counter starts at 0 on accept and the last
    // iteration is the one performed while the count equals these values.
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic [2:0]        r_op;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_divisor;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_is_div;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;

    logic [2*XLEN-1:0] w_pp;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_mul_res;

    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_next;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;
    logic [XLEN-1:0]   w_div_res;

    // ------------------------------------------------------------------
    // Request decode: operands are reduced to magnitudes on accept, and
    // the sign of the result is remembered for the fix-up at the end.
    // ------------------------------------------------------------------
    assign w_accept = req_valid && req_ready;
    assign w_is_div = funct3[2];

    assign w_a_neg = rs1[XLEN-1] && ((funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                                     (funct3 == F_DIV)  || (funct3 == F_REM));
    assign w_b_neg = rs2[XLEN-1] && ((funct3 == F_MULH) ||
                                     (funct3 == F_DIV)  || (funct3 == F_REM));

    assign w_a_mag = w_a_neg ? (~rs1 + 1'b1) : rs1;
    assign w_b_mag = w_b_neg ? (~rs2 + 1'b1) : rs2;

    assign w_div_zero = (rs2 == '0);
    assign w_div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                        (rs1 == INT_MIN) && (rs2 == '1);
    assign w_special  = w_is_div && (w_div_zero || w_div_ovf);

    // funct3[1] selects remainder flavours (REM/REMU).
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? rs1 : '1;
        end else begin
            w_special_res = funct3[1] ? '0 : rs1;
        end
    end

    // ------------------------------------------------------------------
    // Multiply step: add MUL_STEP shifted partial products per cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (r_mplier[i]) begin
                w_pp = w_pp + (r_mcand << i);
            end
        end
    end

    assign w_acc_next = r_acc + w_pp;
    assign w_prod_fix = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_mul_res  = (r_op == F_MUL) ? w_prod_fix[XLEN-1:0]
                                        : w_prod_fix[2*XLEN-1:XLEN];

    // ------------------------------------------------------------------
    // Divide step: shift the next dividend bit into the partial remainder
    // and keep the subtraction only when it does not go negative.
    // ------------------------------------------------------------------
    assign w_shift    = {r_rem, r_quo[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_ge       = !w_diff[XLEN];
    assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], w_ge};

    assign w_q_fix   = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_r_fix   = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
    assign w_div_res = r_op[1] ? w_r_fix : w_q_fix;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (flush overrides every transition)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_special) begin
                        w_state_next = S_DONE;
                    end else if (w_is_div) begin
                        w_state_next = S_DIV;
                    end else begin
                        w_state_next = S_MUL;
                    end
                end
            end
            S_MUL:   if (r_cnt == MUL_LAST) w_state_next = S_DONE;
            S_DIV:   if (r_cnt == DIV_LAST) w_state_next = S_DONE;
            S_DONE:  if (resp_ready)        w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready  = (r_state == S_IDLE) && !flush;
        busy       = (r_state != S_IDLE);
        resp_valid = (r_state == S_DONE);
        resp_data  = r_result;
    end

    // ------------------------------------------------------------------
    // Datapath. The signed result is written into r_result on the last
    // iteration, so it is already final when DONE is entered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_op      <= '0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= funct3;
                        r_cnt     <= '0;
                        r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier  <= w_b_mag;
                        r_acc     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << MUL_STEP;
                    r_mplier <= r_mplier >> MUL_STEP;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == MUL_LAST) begin
                        r_result <= w_mul_res;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == DIV_LAST) begin
                        r_result <= w_div_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
